// File: rtl/mem_stage_pkg.sv
// ============================================================================
// Module   : mem_stage_pkg
// Purpose  : Memory op codes, MEM-stage FSM states and op decode helpers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mem_stage_pkg;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        LB      = 4'd1,
        LH      = 4'd2,
        LW      = 4'd3,
        LBU     = 4'd4,
        LHU     = 4'd5,
        SB      = 4'd6,
        SH      = 4'd7,
        SW      = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_e;

    // Access length in bytes; zero marks a non-memory (or unknown) op.
    function automatic logic [2:0] op_len(input logic [3:0] op);
        logic [2:0] len;
        case (op)
            LB, LBU, SB: len = 3'd1;
            LH, LHU, SH: len = 3'd2;
            LW, SW:      len = 3'd4;
            default:     len = 3'd0;
        endcase
        return len;
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_load_ext.sv
// ============================================================================
// Module   : mem_load_ext
// Purpose  : Sign/zero extension of an assembled load word by op code.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (op)
            LB:      ext = {{24{raw[7]}}, raw[7:0]};
            LBU:     ext = {24'd0, raw[7:0]};
            LH:      ext = {{16{raw[15]}}, raw[15:0]};
            LHU:     ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module   : mem_stage
// Purpose  : RV32I MEM stage; byte-serial loads/stores with pipeline stall.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
)
(
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  ex_we,
    input  logic [31:0]           ex_w_addr,
    input  logic [31:0]           ex_w_data,
    input  logic [3:0]            ex_mem_op,
    input  logic [31:0]           ex_mem_addr,
    input  logic [31:0]           ex_store_data,
    output logic                  mc_req,
    output logic                  mc_wr,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [7:0]            mc_wdata,
    input  logic                  mc_ready,
    input  logic [7:0]            mc_rdata,
    output logic                  mem_we,
    output logic [31:0]           mem_w_addr,
    output logic [31:0]           mem_w_data,
    output logic                  mem_stall
);

    mem_state_e  r_state;
    mem_state_e  w_state_nxt;
    logic [2:0]  r_cnt;
    logic [2:0]  w_cnt_nxt;
    logic [31:0] r_asm;
    logic [31:0] w_asm_nxt;

    logic [2:0]  w_len;
    logic        w_is_mem;
    logic        w_is_store;
    logic [31:0] w_addr_sum;
    logic [7:0]  w_store_byte;
    logic [31:0] w_load_val;

    assign w_len        = op_len(ex_mem_op);
    assign w_is_mem     = (w_len != 3'd0);
    assign w_is_store   = op_is_store(ex_mem_op);
    assign w_addr_sum   = ex_mem_addr + {29'd0, r_cnt};
    assign w_store_byte = ex_store_data[{r_cnt[1:0], 3'b000} +: 8];

    mem_load_ext u_load_ext (
        .op  (ex_mem_op),
        .raw (r_asm),
        .ext (w_load_val)
    );

    // rdy_in low freezes everything, which also makes mc_ready invisible.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= IDLE;
            r_cnt   <= 3'd0;
            r_asm   <= 32'd0;
        end else if (rdy_in) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_asm   <= w_asm_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_asm_nxt   = r_asm;
        mc_req      = 1'b0;
        mc_wr       = 1'b0;
        mc_addr     = '0;
        mc_wdata    = 8'd0;
        mem_we      = 1'b0;
        mem_w_addr  = 32'd0;
        mem_w_data  = 32'd0;
        mem_stall   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_is_mem) begin
                    mem_stall   = 1'b1;
                    w_state_nxt = ACCESS;
                    w_cnt_nxt   = 3'd0;
                    w_asm_nxt   = 32'd0;
                end else begin
                    mem_we     = ex_we;
                    mem_w_addr = ex_w_addr;
                    mem_w_data = ex_w_data;
                end
            end
            ACCESS: begin
                mc_req    = 1'b1;
                mc_wr     = w_is_store;
                mc_addr   = w_addr_sum[ADDR_WIDTH-1:0];
                mc_wdata  = w_store_byte;
                mem_stall = 1'b1;
                if (mc_ready) begin
                    if (!w_is_store) begin
                        w_asm_nxt[{r_cnt[1:0], 3'b000} +: 8] = mc_rdata;
                    end
                    w_cnt_nxt = r_cnt + 3'd1;
                    if ((r_cnt + 3'd1) == w_len) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                if (!w_is_store) begin
                    mem_we     = ex_we;
                    mem_w_addr = ex_w_addr;
                    mem_w_data = w_load_val;
                end
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Outputs are forced quiet for as long as reset is held.
        if (!rst_in) begin
            mc_req     = 1'b0;
            mc_wr      = 1'b0;
            mc_addr    = '0;
            mc_wdata   = 8'd0;
            mem_we     = 1'b0;
            mem_w_addr = 32'd0;
            mem_w_data = 32'd0;
            mem_stall  = 1'b0;
        end
    end

endmodule

`default_nettype wire
